// File: rtl/rv_pkg.sv
// Shared pipeline types and defaults for the register file and its scoreboard.
package rv_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int NREGS_DEF  = 32;
   localparam int ADDR_W_DEF = $clog2(NREGS_DEF);

   typedef logic [XLEN_DEF-1:0]   xlen_t;
   typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus between the ID stage and the register file with scoreboard.
interface reg_file_sb_if #(
   parameter int XLEN   = rv_pkg::XLEN_DEF,
   parameter int NREGS  = rv_pkg::NREGS_DEF,
   parameter int NUM_RD = 2,
   parameter int ADDR_W = $clog2(NREGS)
);

   logic                     WRITE_EN;
   logic [ADDR_W-1:0]        IN_ADDR;
   logic [XLEN-1:0]          DATA_IN;
   logic [NUM_RD-1:0]        RD_EN;
   logic [NUM_RD*ADDR_W-1:0] OUT_ADDR;
   logic [NUM_RD*XLEN-1:0]   DATA_OUT;
   logic                     ISSUE_EN;
   logic [ADDR_W-1:0]        ISSUE_ADDR;
   logic                     FLUSH;
   logic [NREGS-1:0]         BUSY_VEC;
   logic                     STALL;

   modport master (
      output WRITE_EN, IN_ADDR, DATA_IN, RD_EN, OUT_ADDR, ISSUE_EN, ISSUE_ADDR, FLUSH,
      input  DATA_OUT, BUSY_VEC, STALL
   );

   modport slave (
      input  WRITE_EN, IN_ADDR, DATA_IN, RD_EN, OUT_ADDR, ISSUE_EN, ISSUE_ADDR, FLUSH,
      output DATA_OUT, BUSY_VEC, STALL
   );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Busy-bit scoreboard: one bit per destination with an in-flight write, plus the
// read-after-write stall request.
module reg_file_sb_scoreboard
   import rv_pkg::*;
#(
   parameter int NREGS  = NREGS_DEF,
   parameter int ADDR_W = $clog2(NREGS),
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     issue_en,
   input  logic [ADDR_W-1:0]        issue_addr,
   input  logic                     write_en,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic                     flush,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] out_addr,
   output logic [NREGS-1:0]         busy_vec,
   output logic                     stall
);

   logic [NREGS-1:0]  busy_q;
   logic [NREGS-1:0]  busy_d;
   logic [NUM_RD-1:0] port_hit;

   // Flush beats a new issue, and a new issue beats a retiring writer.
   always_comb begin
      busy_d = busy_q;
      for (int r = 1; r < NREGS; r++) begin
         if (flush)
            busy_d[r] = 1'b0;
         else if (issue_en && issue_addr == ADDR_W'(r))
            busy_d[r] = 1'b1;
         else if (write_en && in_addr == ADDR_W'(r))
            busy_d[r] = 1'b0;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_hit
      logic [ADDR_W-1:0] raddr;
      logic              wb_resolves;

      assign raddr       = out_addr[p*ADDR_W +: ADDR_W];
      assign wb_resolves = (BYPASS != 0) && write_en && (in_addr == raddr);
      assign port_hit[p] = rd_en[p] && (raddr != '0) && busy_q[raddr] && !wb_resolves;
   end

   assign busy_vec = busy_q;
   assign stall    = (|port_hit) && !flush && !rst;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with NUM_RD async read ports, one sync write port, optional
// write-to-read bypass and an integrated busy-bit scoreboard.
module reg_file_sb
   import rv_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int ADDR_W = $clog2(NREGS),
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1
) (
   input  logic       CLK,
   input  logic       RESET,
   reg_file_sb_if.slave bus
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic [XLEN-1:0] rd_data [NUM_RD];

   always_comb begin
      regs_d = regs_q;
      if (bus.WRITE_EN && bus.IN_ADDR != '0)
         regs_d[bus.IN_ADDR] = bus.DATA_IN;
      regs_d[0] = '0;
   end

   always_ff @(posedge CLK) begin
      if (RESET)
         regs_q <= '{default: '0};
      else
         regs_q <= regs_d;
   end

   // Bypass is suppressed under reset, since the write it would forward is discarded.
   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] raddr;
      logic              bypass_hit;

      assign raddr      = bus.OUT_ADDR[p*ADDR_W +: ADDR_W];
      assign bypass_hit = (BYPASS != 0) && !RESET && bus.WRITE_EN &&
                          (bus.IN_ADDR != '0) && (bus.IN_ADDR == raddr);
      assign rd_data[p] = (raddr == '0) ? '0 :
                          bypass_hit    ? bus.DATA_IN : regs_q[raddr];
   end

   always_comb begin
      bus.DATA_OUT = '0;
      for (int p = 0; p < NUM_RD; p++)
         bus.DATA_OUT[p*XLEN +: XLEN] = rd_data[p];
   end

   reg_file_sb_scoreboard #(
      .NREGS  (NREGS),
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD),
      .BYPASS (BYPASS)
   ) u_scoreboard (
      .clk        (CLK),
      .rst        (RESET),
      .issue_en   (bus.ISSUE_EN),
      .issue_addr (bus.ISSUE_ADDR),
      .write_en   (bus.WRITE_EN),
      .in_addr    (bus.IN_ADDR),
      .flush      (bus.FLUSH),
      .rd_en      (bus.RD_EN),
      .out_addr   (bus.OUT_ADDR),
      .busy_vec   (bus.BUSY_VEC),
      .stall      (bus.STALL)
   );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: a bypass and a non-bypass instance driven with identical stimulus.
module tb_reg_file_sb;
   import rv_pkg::*;

   logic      CLK = 1'b0;
   logic      RESET;
   logic      we, issue_en, flush;
   reg_addr_t in_addr, issue_addr, ra0, ra1;
   xlen_t     din;
   logic [1:0] rd_en;
   int        total = 0;
   int        passed = 0;

   always #5 CLK = ~CLK;

   reg_file_sb_if #(.XLEN(32), .NREGS(32), .NUM_RD(2)) bus1 ();
   reg_file_sb_if #(.XLEN(32), .NREGS(32), .NUM_RD(2)) bus0 ();

   assign bus1.WRITE_EN = we;        assign bus0.WRITE_EN = we;
   assign bus1.IN_ADDR = in_addr;    assign bus0.IN_ADDR = in_addr;
   assign bus1.DATA_IN = din;        assign bus0.DATA_IN = din;
   assign bus1.RD_EN = rd_en;        assign bus0.RD_EN = rd_en;
   assign bus1.OUT_ADDR = {ra1, ra0}; assign bus0.OUT_ADDR = {ra1, ra0};
   assign bus1.ISSUE_EN = issue_en;  assign bus0.ISSUE_EN = issue_en;
   assign bus1.ISSUE_ADDR = issue_addr; assign bus0.ISSUE_ADDR = issue_addr;
   assign bus1.FLUSH = flush;        assign bus0.FLUSH = flush;

   reg_file_sb #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(1)) dut1 (
      .CLK(CLK), .RESET(RESET), .bus(bus1.slave));
   reg_file_sb #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(0)) dut0 (
      .CLK(CLK), .RESET(RESET), .bus(bus0.slave));

   xlen_t p0_1, p1_1, p0_0, p1_0;
   assign p0_1 = bus1.DATA_OUT[31:0];
   assign p1_1 = bus1.DATA_OUT[63:32];
   assign p0_0 = bus0.DATA_OUT[31:0];
   assign p1_0 = bus0.DATA_OUT[63:32];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; issue_en = 1'b0; flush = 1'b0;
      in_addr = REG_ZERO; issue_addr = REG_ZERO; din = '0;
   endtask

   task automatic test_reset();
      int bad;
      idle();
      for (int r = 1; r < 32; r++) begin
         we = 1'b1; in_addr = reg_addr_t'(r); din = 32'hFFFF_FFFF;
         tick();
      end
      idle();
      issue_en = 1'b1; issue_addr = 5'd3;
      tick();
      idle();
      ra0 = 5'd17; ra1 = 5'd3; rd_en = 2'b11;
      #1;
      total++; if (p0_0 !== 32'hFFFF_FFFF) $display("FAIL preload x17 got %h exp %h", p0_0, 32'hFFFF_FFFF); else passed++;
      total++; if (bus1.STALL !== 1'b1) $display("FAIL preload_stall got %b exp 1", bus1.STALL); else passed++;
      RESET = 1'b1;
      we = 1'b1; in_addr = 5'd17; din = 32'h1111_2222;
      tick();
      total++; if (p0_1 !== 32'h0 || bus1.STALL !== 1'b0) $display("FAIL in_reset x17 got %h stall %b exp 0 0", p0_1, bus1.STALL); else passed++;
      RESET = 1'b0;
      idle();
      bad = 0;
      for (int r = 1; r < 32; r++) begin
         ra0 = reg_addr_t'(r); ra1 = reg_addr_t'(r);
         #1;
         if (p0_1 !== 32'h0 || p1_1 !== 32'h0 || p0_0 !== 32'h0) bad++;
      end
      total++; if (bad != 0) $display("FAIL reset_regs got %0d nonzero exp 0", bad); else passed++;
      total++; if (bus1.BUSY_VEC !== 32'h0 || bus0.BUSY_VEC !== 32'h0) $display("FAIL reset_busy got %h exp 0", bus1.BUSY_VEC); else passed++;
      ra0 = 5'd3;
      #1;
      total++; if (bus1.STALL !== 1'b0) $display("FAIL reset_stall got %b exp 0", bus1.STALL); else passed++;
   endtask

   task automatic test_bypass();
      idle();
      rd_en = 2'b00; ra0 = 5'd5; ra1 = 5'd6;
      we = 1'b1; in_addr = 5'd5; din = 32'hDEAD_BEEF;
      #1;
      total++; if (p0_1 !== 32'hDEAD_BEEF) $display("FAIL bypass_on got %h exp %h", p0_1, 32'hDEAD_BEEF); else passed++;
      total++; if (p0_0 !== 32'h0) $display("FAIL bypass_off_old got %h exp 0", p0_0); else passed++;
      total++; if (p1_1 !== 32'h0) $display("FAIL bypass_other_port got %h exp 0", p1_1); else passed++;
      tick();
      idle();
      #1;
      total++; if (p0_0 !== 32'hDEAD_BEEF) $display("FAIL bypass_off_next got %h exp %h", p0_0, 32'hDEAD_BEEF); else passed++;
      total++; if (p0_1 !== 32'hDEAD_BEEF) $display("FAIL bypass_on_next got %h exp %h", p0_1, 32'hDEAD_BEEF); else passed++;
   endtask

   task automatic test_reg_zero();
      idle();
      ra0 = REG_ZERO; ra1 = REG_ZERO; rd_en = 2'b11;
      we = 1'b1; in_addr = REG_ZERO; din = 32'h0000_1234;
      issue_en = 1'b1; issue_addr = REG_ZERO;
      #1;
      total++; if (p0_1 !== 32'h0 || p1_1 !== 32'h0) $display("FAIL x0_bypass got %h %h exp 0 0", p0_1, p1_1); else passed++;
      tick();
      idle();
      #1;
      total++; if (p0_1 !== 32'h0 || p1_1 !== 32'h0 || p0_0 !== 32'h0 || p1_0 !== 32'h0) $display("FAIL x0_read got %h %h exp 0 0", p0_0, p1_0); else passed++;
      total++; if (bus1.BUSY_VEC !== 32'h0 || bus1.STALL !== 1'b0) $display("FAIL x0_busy got %h stall %b exp 0 0", bus1.BUSY_VEC, bus1.STALL); else passed++;
      rd_en = 2'b00;
   endtask

   task automatic test_stall_writeback();
      idle();
      issue_en = 1'b1; issue_addr = 5'd7;
      tick();
      idle();
      rd_en = 2'b01; ra0 = 5'd7; ra1 = 5'd0;
      #1;
      total++; if (bus1.STALL !== 1'b1 || bus0.STALL !== 1'b1) $display("FAIL stall_raw got %b %b exp 1 1", bus1.STALL, bus0.STALL); else passed++;
      total++; if (bus1.BUSY_VEC !== 32'h0000_0080) $display("FAIL busy7 got %h exp %h", bus1.BUSY_VEC, 32'h80); else passed++;
      tick();
      tick();
      we = 1'b1; in_addr = 5'd7; din = 32'h55;
      #1;
      total++; if (bus1.STALL !== 1'b0 || p0_1 !== 32'h55) $display("FAIL wb_bypass got stall %b data %h exp 0 55", bus1.STALL, p0_1); else passed++;
      total++; if (bus0.STALL !== 1'b1) $display("FAIL wb_nobypass_stall got %b exp 1", bus0.STALL); else passed++;
      tick();
      idle();
      #1;
      total++; if (bus1.BUSY_VEC !== 32'h0 || bus0.BUSY_VEC !== 32'h0) $display("FAIL busy7_clear got %h exp 0", bus1.BUSY_VEC); else passed++;
      total++; if (bus0.STALL !== 1'b0 || p0_0 !== 32'h55) $display("FAIL wb_after got stall %b data %h exp 0 55", bus0.STALL, p0_0); else passed++;
      rd_en = 2'b00;
   endtask

   task automatic test_issue_and_wb_same();
      idle();
      issue_en = 1'b1; issue_addr = 5'd9;
      we = 1'b1; in_addr = 5'd9; din = 32'hA0;
      tick();
      idle();
      ra0 = 5'd9; rd_en = 2'b01;
      #1;
      total++; if (p0_0 !== 32'hA0) $display("FAIL same_cycle_data got %h exp a0", p0_0); else passed++;
      total++; if (bus1.BUSY_VEC !== 32'h0000_0200 || bus0.BUSY_VEC !== 32'h0000_0200) $display("FAIL same_cycle_busy got %h exp %h", bus1.BUSY_VEC, 32'h200); else passed++;
      total++; if (bus1.STALL !== 1'b1) $display("FAIL same_cycle_stall got %b exp 1", bus1.STALL); else passed++;
      rd_en = 2'b00;
   endtask

   task automatic test_flush();
      idle();
      issue_en = 1'b1; issue_addr = 5'd3;
      tick();
      issue_addr = 5'd4;
      tick();
      idle();
      #1;
      total++; if (bus1.BUSY_VEC !== 32'h0000_0218) $display("FAIL pre_flush_busy got %h exp %h", bus1.BUSY_VEC, 32'h218); else passed++;
      flush = 1'b1;
      issue_en = 1'b1; issue_addr = 5'd6;
      we = 1'b1; in_addr = 5'd3; din = 32'h33;
      rd_en = 2'b11; ra0 = 5'd4; ra1 = 5'd9;
      #1;
      total++; if (bus1.STALL !== 1'b0 || bus0.STALL !== 1'b0) $display("FAIL flush_stall got %b %b exp 0 0", bus1.STALL, bus0.STALL); else passed++;
      tick();
      idle();
      ra1 = 5'd3;
      #1;
      total++; if (bus1.BUSY_VEC !== 32'h0 || bus0.BUSY_VEC !== 32'h0) $display("FAIL flush_busy got %h exp 0", bus1.BUSY_VEC); else passed++;
      total++; if (p1_0 !== 32'h33) $display("FAIL flush_write got %h exp 33", p1_0); else passed++;
      total++; if (bus1.STALL !== 1'b0) $display("FAIL post_flush_stall got %b exp 0", bus1.STALL); else passed++;
      rd_en = 2'b00;
   endtask

   task automatic test_back_to_back();
      idle();
      we = 1'b1; in_addr = 5'd10; din = 32'h1010_1010;
      tick();
      in_addr = 5'd11; din = 32'h1111_0000;
      tick();
      in_addr = 5'd12; din = 32'h00C0_FFEE;
      ra0 = 5'd12; ra1 = 5'd12;
      #1;
      total++; if (p0_1 !== 32'h00C0_FFEE || p1_1 !== 32'h00C0_FFEE) $display("FAIL dual_bypass got %h %h exp 00c0ffee", p0_1, p1_1); else passed++;
      total++; if (p0_0 !== 32'h0 || p1_0 !== 32'h0) $display("FAIL dual_nobypass got %h %h exp 0 0", p0_0, p1_0); else passed++;
      tick();
      idle();
      ra0 = 5'd10; ra1 = 5'd11;
      #1;
      total++; if (p0_0 !== 32'h1010_1010 || p1_0 !== 32'h1111_0000) $display("FAIL b2b_read got %h %h exp 10101010 11110000", p0_0, p1_0); else passed++;
      ra0 = 5'd12;
      #1;
      total++; if (p0_0 !== 32'h00C0_FFEE) $display("FAIL b2b_x12 got %h exp 00c0ffee", p0_0); else passed++;
   endtask

   initial begin
      RESET = 1'b1;
      idle();
      rd_en = 2'b00; ra0 = REG_ZERO; ra1 = REG_ZERO;
      tick();
      tick();
      RESET = 1'b0;
      test_reset();
      test_bypass();
      test_reg_zero();
      test_stall_writeback();
      test_issue_and_wb_same();
      test_flush();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
